// File: rtl/eth_parser_pkg.sv
// Shared types and constants for the Ethernet L2 header decoder: the
// descriptor layout, the EtherType classes and the decoder FSM states.
package eth_parser_pkg;

  localparam logic [15:0] ETYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ETYPE_IPV6 = 16'h86DD;
  localparam logic [15:0] ETYPE_ARP  = 16'h0806;
  localparam logic [15:0] ETYPE_VLAN = 16'h8100;
  localparam logic [15:0] ETYPE_QINQ = 16'h88A8;

  // Byte offset of the L3 header for untagged and single-tagged frames
  localparam logic [4:0] L2_HDR_LEN      = 5'd14;
  localparam logic [4:0] L2_VLAN_HDR_LEN = 5'd18;

  // CLS_OTHER is encoded as zero so that an all-zero descriptor classifies as OTHER
  typedef enum logic [1:0] {
    CLS_OTHER = 2'd0,
    CLS_IPV4  = 2'd1,
    CLS_IPV6  = 2'd2,
    CLS_ARP   = 2'd3
  } eth_class_e;

  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic        vlan_present;
    logic [15:0] vlan_tci;
    logic [15:0] ethertype;
    logic [4:0]  l3_offset;
    logic        is_bcast;
    logic        is_mcast;
    eth_class_e  eth_class;
    logic        parse_error;
  } eth_desc_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HDR   = 2'd1,
    ST_GRACE = 2'd2,
    ST_BODY  = 2'd3
  } dec_state_e;

  // Map an EtherType onto the coarse L3 class carried in the descriptor
  function automatic eth_class_e classify(input logic [15:0] etype);
    eth_class_e cls;
    case (etype)
      ETYPE_IPV4: cls = CLS_IPV4;
      ETYPE_IPV6: cls = CLS_IPV6;
      ETYPE_ARP:  cls = CLS_ARP;
      default:    cls = CLS_OTHER;
    endcase
    return cls;
  endfunction

  // Descriptor emitted for a frame that ended before its header was complete
  function automatic eth_desc_t runt_desc();
    eth_desc_t d;
    d             = '0;
    d.eth_class   = CLS_OTHER;
    d.parse_error = 1'b1;
    return d;
  endfunction

endpackage

// File: rtl/eth_desc_fifo.sv
// Small synchronous FIFO for descriptors. A push into a full FIFO is still
// accepted when a pop happens in the same cycle; push_ok reports acceptance.
// pop_data reads as zero while the FIFO is empty.
module eth_desc_fifo #(
  parameter type         T     = logic [7:0],
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     push_data,
  output logic push_ok,
  input  logic pop,
  output T     pop_data,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_ok;
  T              mem_q [DEPTH];

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Head-of-queue read, forced to zero when nothing is buffered
  always_comb begin
    pop_data = mem_q[rd_ptr_q];
    if (empty) begin
      pop_data = '0;
    end
  end

  // Next-state for pointers and occupancy; depth is a power of two so pointers wrap naturally
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state: pointers and occupancy, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are never reset, emptiness is tracked by count_q
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/eth_header_decoder.sv
// Ethernet L2 header decoder. Decodes the captured header combinationally,
// tracks frame boundaries with a small FSM, queues one descriptor per frame
// and counts accepted and dropped descriptors.
module eth_header_decoder
  import eth_parser_pkg::*;
#(
  parameter int unsigned HEADER_BYTES = 18,
  parameter int unsigned FIFO_DEPTH   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_start,
  input  logic                         frame_end,
  input  logic [HEADER_BYTES-1:0][7:0] header_bytes,
  input  logic                         header_valid,
  output logic                         out_valid,
  input  logic                         out_ready,
  output eth_desc_t                    out_desc,
  output logic [31:0]                  frame_count,
  output logic [15:0]                  drop_count
);

  dec_state_e  state_q, state_d;
  eth_desc_t   dec_desc;
  eth_desc_t   push_desc;
  logic [15:0] outer_type;
  logic        push;
  logic        push_ok;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [31:0] frame_count_q, frame_count_d;
  logic [15:0] drop_count_q, drop_count_d;

  // Combinational field decode; wire byte 0 is the most significant byte of each field
  always_comb begin
    dec_desc         = '0;
    outer_type       = {header_bytes[12], header_bytes[13]};
    dec_desc.dst_mac = {header_bytes[0], header_bytes[1], header_bytes[2],
                        header_bytes[3], header_bytes[4], header_bytes[5]};
    dec_desc.src_mac = {header_bytes[6], header_bytes[7], header_bytes[8],
                        header_bytes[9], header_bytes[10], header_bytes[11]};
    if ((outer_type == ETYPE_VLAN) || (outer_type == ETYPE_QINQ)) begin
      dec_desc.vlan_present = 1'b1;
      dec_desc.vlan_tci     = {header_bytes[14], header_bytes[15]};
      dec_desc.ethertype    = {header_bytes[16], header_bytes[17]};
      dec_desc.l3_offset    = L2_VLAN_HDR_LEN;
    end else begin
      dec_desc.vlan_present = 1'b0;
      dec_desc.vlan_tci     = '0;
      dec_desc.ethertype    = outer_type;
      dec_desc.l3_offset    = L2_HDR_LEN;
    end
    dec_desc.is_bcast    = &dec_desc.dst_mac;
    dec_desc.is_mcast    = header_bytes[0][0];
    dec_desc.eth_class   = classify(dec_desc.ethertype);
    dec_desc.parse_error = 1'b0;
  end

  // Frame-tracking FSM next state and descriptor push decision
  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    push_desc = dec_desc;
    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        // A new frame start abandons the current header without a descriptor
        if (frame_start) begin
          state_d = ST_HDR;
        end else if (header_valid) begin
          push    = 1'b1;
          state_d = frame_end ? ST_IDLE : ST_BODY;
        end else if (frame_end) begin
          state_d = ST_GRACE;
        end
      end
      ST_GRACE: begin
        // The capture stage may deliver header_valid one cycle after tlast;
        // without it the frame was too short and becomes a runt.
        push = 1'b1;
        if (!header_valid) begin
          push_desc = runt_desc();
        end
        state_d = frame_start ? ST_HDR : ST_IDLE;
      end
      ST_BODY: begin
        if (frame_start) begin
          state_d = ST_HDR;
        end else if (frame_end) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  eth_desc_fifo #(
    .T     (eth_desc_t),
    .DEPTH (FIFO_DEPTH)
  ) u_desc_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_desc),
    .push_ok   (push_ok),
    .pop       (pop),
    .pop_data  (out_desc),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Accepted descriptors wrap; drops saturate so a stuck consumer stays visible
  always_comb begin
    frame_count_d = frame_count_q;
    drop_count_d  = drop_count_q;
    if (push_ok) begin
      frame_count_d = frame_count_q + 32'd1;
    end
    if (push && !push_ok && (drop_count_q != 16'hFFFF)) begin
      drop_count_d = drop_count_q + 16'd1;
    end
  end

  // Statistics counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      frame_count_q <= frame_count_d;
      drop_count_q  <= drop_count_d;
    end
  end

  assign frame_count = frame_count_q;
  assign drop_count  = drop_count_q;

  // fifo_full is implied by push_ok; kept for observability in waveforms
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_eth_header_decoder.sv
// Randomised bench for eth_header_decoder with a queue-based reference model.
module tb_eth_header_decoder;
  import eth_parser_pkg::*;

  localparam int HB    = 18;
  localparam int DEPTH = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                frame_start = 1'b0;
  logic                frame_end = 1'b0;
  logic [HB-1:0][7:0]  header_bytes = '0;
  logic                header_valid = 1'b0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  eth_desc_t           out_desc;
  logic [31:0]         frame_count;
  logic [15:0]         drop_count;

  eth_header_decoder #(.HEADER_BYTES(HB), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .frame_end    (frame_end),
    .header_bytes (header_bytes),
    .header_valid (header_valid),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_desc     (out_desc),
    .frame_count  (frame_count),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  int          n_total = 0;
  int          n_bad   = 0;
  int          ready_mode = 0;   // 0: always ready, 1: stalled, 2: random
  logic        exp_push = 1'b0;
  eth_desc_t   exp_item = '0;
  eth_desc_t   runt_exp;
  eth_desc_t   mq[$];
  int unsigned m_frames = 0;
  int unsigned m_drops  = 0;
  logic [7:0]  hb [HB];

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode written directly from the field rules
  function automatic eth_desc_t ref_decode(input logic [7:0] b [HB]);
    eth_desc_t d;
    int t, et;
    d = '0;
    for (int i = 0; i < 6; i++) begin
      d.dst_mac = (d.dst_mac << 8) | 48'(b[i]);
      d.src_mac = (d.src_mac << 8) | 48'(b[6+i]);
    end
    t = int'(b[12]) * 256 + int'(b[13]);
    if (t == 'h8100 || t == 'h88A8) begin
      d.vlan_present = 1'b1;
      d.vlan_tci     = 16'(int'(b[14]) * 256 + int'(b[15]));
      et             = int'(b[16]) * 256 + int'(b[17]);
      d.l3_offset    = 5'd18;
    end else begin
      et          = t;
      d.l3_offset = 5'd14;
    end
    d.ethertype = 16'(et);
    d.is_bcast  = (d.dst_mac == 48'hFFFF_FFFF_FFFF);
    d.is_mcast  = (b[0] % 2) == 1;
    if (et == 'h0800)      d.eth_class = CLS_IPV4;
    else if (et == 'h86DD) d.eth_class = CLS_IPV6;
    else if (et == 'h0806) d.eth_class = CLS_ARP;
    else                   d.eth_class = CLS_OTHER;
    return d;
  endfunction

  // Consumer readiness
  always @(negedge clk) begin
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Scoreboard: bounded queue with pop-before-push, then compare after the edge
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_frames = 0;
      m_drops  = 0;
    end else begin
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      if (exp_push) begin
        if (mq.size() < DEPTH) begin
          mq.push_back(exp_item);
          m_frames++;
        end else if (m_drops != 'hFFFF) begin
          m_drops++;
        end
      end
    end
    #1;
    if (rst) begin
      chk("rst_valid", 160'(out_valid), 160'(0));
      chk("rst_desc", 160'(out_desc), 160'(0));
      chk("rst_fcnt", 160'(frame_count), 160'(0));
      chk("rst_dcnt", 160'(drop_count), 160'(0));
    end else begin
      chk("valid", 160'(out_valid), 160'(mq.size() > 0));
      if (mq.size() > 0) chk("desc", 160'(out_desc), 160'(mq[0]));
      chk("fcnt", 160'(frame_count), 160'(m_frames));
      chk("dcnt", 160'(drop_count), 160'(m_drops));
    end
  end

  task automatic drive(input logic fs, input logic fe, input logic hv,
                       input logic ep, input eth_desc_t ed);
    @(negedge clk);
    frame_start  = fs;
    frame_end    = fe;
    header_valid = hv;
    exp_push     = ep;
    exp_item     = ed;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic load_hdr();
    for (int i = 0; i < HB; i++) header_bytes[i] = hb[i];
  endtask

  task automatic rand_hdr();
    for (int i = 0; i < HB; i++) hb[i] = 8'($urandom);
    case ($urandom_range(0, 7))
      0: {hb[12], hb[13]} = 16'h0800;
      1: {hb[12], hb[13]} = 16'h86DD;
      2: {hb[12], hb[13]} = 16'h0806;
      3, 4: {hb[12], hb[13]} = 16'h8100;
      5: {hb[12], hb[13]} = 16'h88A8;
      default: ;
    endcase
    case ($urandom_range(0, 3))
      0: {hb[16], hb[17]} = 16'h0800;
      1: {hb[16], hb[17]} = 16'h86DD;
      2: {hb[16], hb[17]} = 16'h0806;
      default: ;
    endcase
    if ($urandom_range(0, 4) == 0) for (int i = 0; i < 6; i++) hb[i] = 8'hFF;
  endtask

  // mode 0 normal, 1 header_valid with tlast, 2 header via grace, 3 runt,
  // 4 restart in HDR, 5 runt in grace with immediate new frame start
  task automatic send_frame(input int mode);
    eth_desc_t d;
    int hdly, body;
    load_hdr();
    d    = ref_decode(hb);
    hdly = $urandom_range(0, 2);
    body = $urandom_range(0, 3);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    if (mode == 4) begin
      idle(1);
      drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    end
    if (mode == 5) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
      drive(1'b1, 1'b0, 1'b0, 1'b1, runt_exp);
    end
    idle(hdly);
    case (mode)
      1: drive(1'b0, 1'b1, 1'b1, 1'b1, d);
      2: begin
        drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, d);
      end
      3: begin
        drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, runt_exp);
      end
      default: begin
        drive(1'b0, 1'b0, 1'b1, 1'b1, d);
        idle(body);
        drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
      end
    endcase
    idle($urandom_range(1, 2));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b1;
    frame_start  = 1'b0;
    frame_end    = 1'b0;
    header_valid = 1'b0;
    exp_push     = 1'b0;
    #1;
    chk("rst_async_valid", 160'(out_valid), 160'(0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [47:0] first_dst;
    logic [31:0] fc0;
    runt_exp             = '0;
    runt_exp.eth_class   = CLS_OTHER;
    runt_exp.parse_error = 1'b1;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Untagged IPv4 unicast
    ready_mode = 1;
    do_reset();
    rand_hdr();
    {hb[0], hb[1], hb[2], hb[3], hb[4], hb[5]} = 48'h0011_2233_4455;
    {hb[12], hb[13]} = 16'h0800;
    send_frame(0);
    chk("ipv4_valid", 160'(out_valid), 160'(1));
    chk("ipv4_dst", 160'(out_desc.dst_mac), 160'(48'h0011_2233_4455));
    chk("ipv4_vlan", 160'(out_desc.vlan_present), 160'(0));
    chk("ipv4_l3off", 160'(out_desc.l3_offset), 160'(14));
    chk("ipv4_class", 160'(out_desc.eth_class), 160'(CLS_IPV4));
    chk("ipv4_mcast", 160'(out_desc.is_mcast), 160'(0));
    ready_mode = 0;
    idle(3);

    // Tagged IPv6 broadcast
    ready_mode = 1;
    idle(1);
    rand_hdr();
    for (int i = 0; i < 6; i++) hb[i] = 8'hFF;
    {hb[12], hb[13], hb[14], hb[15], hb[16], hb[17]} = 48'h8100_6064_86DD;
    send_frame(0);
    chk("vlan_tci", 160'(out_desc.vlan_tci), 160'(16'h6064));
    chk("vlan_etype", 160'(out_desc.ethertype), 160'(16'h86DD));
    chk("vlan_l3off", 160'(out_desc.l3_offset), 160'(18));
    chk("vlan_bcast", 160'(out_desc.is_bcast), 160'(1));
    chk("vlan_mcast", 160'(out_desc.is_mcast), 160'(1));
    ready_mode = 0;
    idle(3);

    // Header completed in the grace cycle, then a runt
    rand_hdr();
    fc0 = frame_count;
    send_frame(2);
    chk("grace_fcnt", 160'(frame_count), 160'(fc0 + 1));
    fc0 = frame_count;
    ready_mode = 1;
    idle(1);
    send_frame(3);
    chk("runt_perr", 160'(out_desc.parse_error), 160'(1));
    chk("runt_fcnt", 160'(frame_count), 160'(fc0 + 1));
    ready_mode = 0;
    idle(3);

    // Backpressure: three frames into a two-entry buffer
    ready_mode = 1;
    do_reset();
    rand_hdr();
    first_dst = {hb[0], hb[1], hb[2], hb[3], hb[4], hb[5]};
    send_frame(0);
    rand_hdr();
    send_frame(1);
    rand_hdr();
    send_frame(0);
    chk("bp_fcnt", 160'(frame_count), 160'(2));
    chk("bp_dcnt", 160'(drop_count), 160'(1));
    chk("bp_head", 160'(out_desc.dst_mac), 160'(first_dst));
    ready_mode = 0;
    idle(4);

    // Restart mid-header yields one descriptor; reset while holding output
    do_reset();
    rand_hdr();
    send_frame(4);
    chk("restart_fcnt", 160'(frame_count), 160'(1));
    ready_mode = 1;
    idle(1);
    rand_hdr();
    send_frame(0);
    chk("pre_rst_valid", 160'(out_valid), 160'(1));
    do_reset();
    chk("post_rst_fcnt", 160'(frame_count), 160'(0));
    chk("post_rst_dcnt", 160'(drop_count), 160'(0));
    ready_mode = 0;
    idle(2);

    // Randomised traffic with random backpressure
    ready_mode = 2;
    for (int f = 0; f < 300; f++) begin
      rand_hdr();
      send_frame($urandom_range(0, 5));
    end
    ready_mode = 0;
    idle(6);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/eth_header_decoder.md
ETH_HEADER_DECODER -- requirements
Module: eth_header_decoder

Interface
REQ-001 SHALL have parameter HEADER_BYTES, default 18, header bytes presented by the capture stage.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, descriptor buffer entries, power of two, minimum 2.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have clk  input  1  rising-edge clock.
REQ-005 SHALL have rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have frame_start  input  1  first beat of a new frame accepted.
REQ-007 SHALL have frame_end  input  1  last beat (tlast) of the current frame accepted.
REQ-008 SHALL have header_bytes  input  HEADER_BYTES x 8  captured header; index 0 is the first wire byte.
REQ-009 SHALL have header_valid  input  1  single-cycle pulse: all HEADER_BYTES captured.
REQ-010 SHALL have out_valid / out_ready  output / input  1 / 1  descriptor handshake.
REQ-011 SHALL have out_desc  output  eth_desc_t  dst_mac[48], src_mac[48], vlan_present, vlan_tci[16], ethertype[16], l3_offset[5], is_bcast, is_mcast, eth_class[2], parse_error.
REQ-012 SHALL have frame_count  output  32  descriptors accepted into buffer, wrapping.
REQ-013 SHALL have drop_count  output  16  descriptors lost to a full buffer, saturating at 0xFFFF.

Function
REQ-014 SHALL decode fields big-endian: dst_mac={b0..b5}, src_mac={b6..b11}, outer type T={b12,b13}.
REQ-015 SHALL set vlan_present=1 when T is 0x8100 or 0x88A8; then vlan_tci={b14,b15}, ethertype={b16,b17}, l3_offset=18; else vlan_tci=0, ethertype=T, l3_offset=14.
REQ-016 SHALL set is_bcast when dst_mac==FF:FF:FF:FF:FF:FF, and is_mcast when b0[0]==1 (includes broadcast).
REQ-017 SHALL set eth_class from ethertype: 0x0800 IPV4, 0x86DD IPV6, 0x0806 ARP, else OTHER.
REQ-018 SHALL run FSM states IDLE, HDR, GRACE, BODY.
REQ-019 IDLE: frame_start -> HDR; all other inputs ignored.
REQ-020 HDR: header_valid -> push decoded descriptor, go BODY, or IDLE if frame_end is also high; frame_end alone -> GRACE.
REQ-021 GRACE (one cycle, covers registered header_valid): header_valid -> push decoded, IDLE; else push runt descriptor (all fields 0, eth_class OTHER, parse_error=1), IDLE.
REQ-022 BODY: frame_end -> IDLE; header_valid ignored.
REQ-023 frame_start in HDR or BODY SHALL restart to HDR without pushing; in GRACE it SHALL push the GRACE result and go HDR in the same cycle.
REQ-024 A pushed descriptor SHALL appear on out_valid/out_desc the cycle after the push when the buffer was empty (latency 1 from header_valid).
REQ-025 out_desc SHALL hold stable while out_valid=1 and out_ready=0; pop occurs on out_valid&&out_ready.
REQ-026 Push into a full buffer SHALL succeed if a pop happens the same cycle; otherwise the descriptor is discarded and drop_count increments.
REQ-027 frame_count SHALL increment once per accepted push, including runt descriptors.

Reset
REQ-028 On rst: FSM=IDLE, buffer empty, out_valid=0, out_desc=0, frame_count=0, drop_count=0.
REQ-029 Reset mid-frame SHALL discard buffered descriptors and the in-progress frame; the first frame_start after deassertion starts cleanly.

Structure
REQ-030 eth_parser_pkg SHALL hold eth_desc_t, eth_class_e, ETYPE_IPV4/IPV6/ARP/VLAN/QINQ constants and L2_HDR_LEN/L2_VLAN_HDR_LEN.
REQ-031 Descriptor buffering SHALL be sub-module eth_desc_fifo (sync FIFO, parameterised type and depth, full/empty flags).
REQ-032 Field decode SHALL be combinational from header_bytes; only FSM, FIFO and counters are registered.

Verification
REQ-033 Untagged IPv4 frame, dst 00:11:22:33:44:55, T=0x0800 -> one descriptor next cycle: vlan_present=0, l3_offset=14, eth_class IPV4, is_mcast=0.
REQ-034 Tagged frame T=0x8100, TCI=0x6064, inner 0x86DD, dst FF..FF -> vlan_tci=0x6064, ethertype=0x86DD, l3_offset=18, is_bcast=1, is_mcast=1.
REQ-035 frame_end on beat 3, header_valid next cycle -> normal descriptor via GRACE; 10-byte frame -> runt descriptor, parse_error=1, frame_count+1.
REQ-036 out_ready=0, three frames -> two descriptors held, drop_count=1, frame_count=2; release -> descriptors in order.
REQ-037 frame_start mid-HDR, then full frame -> exactly one descriptor; rst asserted with out_valid=1 -> out_valid=0 and counters 0 next edge.
